// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship board logic: cell codes, board
// geometry, the board type and the fleet placer state encoding.
package battleship_pkg;

  localparam int BOARD_N   = 5;
  localparam int MAX_SHIPS = 5;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_WATER = 2'b00;
  localparam cell_t CELL_SHIP  = 2'b01;
  localparam cell_t CELL_HIT   = 2'b10;
  localparam cell_t CELL_MISS  = 2'b11;

  // Indexed as board[row][col].
  typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  typedef enum logic [2:0] {
    PL_IDLE,
    PL_CLEAR,
    PL_PICK,
    PL_CHECK,
    PL_COMMIT,
    PL_FALLBACK,
    PL_DONE
  } placer_state_t;

  // Requested ship count limited to what fits the board.
  function automatic logic [2:0] clamp_ships(input logic [2:0] req);
    return (req > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS) : req;
  endfunction

  // Fixed layout: ship of length L on row L-1, cols 0..L-1, for L=1..n.
  function automatic board_t fallback_board(input logic [2:0] n);
    board_t b;
    for (int r = 0; r < BOARD_N; r++) begin
      for (int c = 0; c < BOARD_N; c++) begin
        b[r][c] = (r < int'(n) && c <= r) ? CELL_SHIP : CELL_WATER;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/pc_fleet_placer_if.sv
// Setup-phase request / PC board result bundle between the game setup logic
// (master) and the fleet placer (slave).
interface pc_fleet_placer_if;
  import battleship_pkg::*;

  logic       start;
  logic [2:0] ship_count;
  board_t     tablero_pc;
  logic [2:0] pc_ships;
  logic       busy;
  logic       done;
  logic       placement_fallback;

  modport master (
    output start, ship_count,
    input  tablero_pc, pc_ships, busy, done, placement_fallback
  );

  modport slave (
    input  start, ship_count,
    output tablero_pc, pc_ships, busy, done, placement_fallback
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11. Loads seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb;

  assign fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

  // Shift every cycle; the seed must be non-zero or the sequence sticks at 0.
  always_ff @(posedge clk) begin
    if (rst) q_q <= seed;
    else     q_q <= {q_q[14:0], fb};
  end

  assign q = q_q;

endmodule

// File: rtl/pc_fleet_placer.sv
// Builds the computer's fleet on the 5x5 board: random placement, largest
// ship first, with a bounded retry count per ship and a fixed fallback layout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | board held, waiting for start
// CLEAR    | wipe board and counters, load L=N
// PICK     | sample LFSR for origin/orientation, reject if off-board
// CHECK    | walk the candidate cells one per cycle, reject on overlap
// COMMIT   | write the ship one cell per cycle, then next ship or done
// FALLBACK | too many rejects: write the fixed staircase layout
// DONE     | one-cycle done pulse, drop busy
module pc_fleet_placer
  import battleship_pkg::*;
#(
  parameter int          MAX_TRIES = 32,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  pc_fleet_placer_if.slave  bus
);

  localparam int         TW  = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [2:0] BN3 = 3'(BOARD_N);
  localparam logic [3:0] BN4 = 4'(BOARD_N);

  placer_state_t state_q;
  board_t        board_q;
  logic [2:0]    pc_ships_q;
  logic          busy_q;
  logic          done_q;
  logic          fallback_q;
  logic [2:0]    n_q;
  logic [2:0]    len_q;
  logic [2:0]    idx_q;
  logic [2:0]    row_q;
  logic [2:0]    col_q;
  logic          vert_q;
  logic [TW-1:0] tries_q;

  logic [15:0] lfsr;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:7];

  // Candidate taken straight from the LFSR in PICK.
  logic [2:0] pick_row, pick_col;
  logic       pick_vert;
  logic [3:0] pick_end_r, pick_end_c;
  logic       pick_ok;

  assign pick_row   = lfsr[2:0];
  assign pick_col   = lfsr[5:3];
  assign pick_vert  = lfsr[6];
  assign pick_end_r = {1'b0, pick_row} + {1'b0, len_q};
  assign pick_end_c = {1'b0, pick_col} + {1'b0, len_q};
  assign pick_ok    = (pick_row < BN3) && (pick_col < BN3) &&
                      (pick_vert ? (pick_end_r <= BN4) : (pick_end_c <= BN4));

  // Cell currently being checked or written.
  logic [2:0] cur_r, cur_c;
  logic       idx_last;
  logic       tries_last;

  assign cur_r      = row_q + (vert_q ? idx_q : 3'd0);
  assign cur_c      = col_q + (vert_q ? 3'd0 : idx_q);
  assign idx_last   = (idx_q == len_q - 3'd1);
  assign tries_last = (int'(tries_q) + 1 >= MAX_TRIES);

  // Placement FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PL_IDLE;
      board_q    <= '0;
      pc_ships_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fallback_q <= 1'b0;
      n_q        <= 3'd0;
      len_q      <= 3'd0;
      idx_q      <= 3'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      vert_q     <= 1'b0;
      tries_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PL_IDLE: begin
          if (bus.start) begin
            n_q     <= clamp_ships(bus.ship_count);
            busy_q  <= 1'b1;
            state_q <= PL_CLEAR;
          end
        end
        PL_CLEAR: begin
          board_q    <= '0;
          pc_ships_q <= 3'd0;
          fallback_q <= 1'b0;
          tries_q    <= '0;
          idx_q      <= 3'd0;
          len_q      <= n_q;
          state_q    <= (n_q == 3'd0) ? PL_DONE : PL_PICK;
        end
        PL_PICK: begin
          if (MAX_TRIES == 0) begin
            state_q <= PL_FALLBACK;
          end else if (pick_ok) begin
            row_q   <= pick_row;
            col_q   <= pick_col;
            vert_q  <= pick_vert;
            idx_q   <= 3'd0;
            state_q <= PL_CHECK;
          end else begin
            tries_q <= tries_q + TW'(1);
            if (tries_last) state_q <= PL_FALLBACK;
          end
        end
        PL_CHECK: begin
          if (board_q[cur_r][cur_c] != CELL_WATER) begin
            tries_q <= tries_q + TW'(1);
            state_q <= tries_last ? PL_FALLBACK : PL_PICK;
          end else if (idx_last) begin
            idx_q   <= 3'd0;
            state_q <= PL_COMMIT;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        PL_COMMIT: begin
          board_q[cur_r][cur_c] <= CELL_SHIP;
          if (idx_last) begin
            idx_q      <= 3'd0;
            pc_ships_q <= pc_ships_q + 3'd1;
            tries_q    <= '0;
            len_q      <= len_q - 3'd1;
            state_q    <= (len_q == 3'd1) ? PL_DONE : PL_PICK;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        PL_FALLBACK: begin
          board_q    <= fallback_board(n_q);
          pc_ships_q <= n_q;
          fallback_q <= 1'b1;
          state_q    <= PL_DONE;
        end
        PL_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= PL_IDLE;
        end
        default: state_q <= PL_IDLE;
      endcase
    end
  end

  assign bus.tablero_pc         = board_q;
  assign bus.pc_ships           = pc_ships_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.placement_fallback = fallback_q;

endmodule

// File: doc/pc_fleet_placer.md
Name: pc_fleet_placer

Overview:
- Generates the computer's fleet on the 5x5 PC board before the first player turn.
- Sits upstream of the game FSM and the VGA display.
- Consumes the clamped player ship count and a start pulse from the setup phase. Produces the filled PC board, the PC ship count used by the FSM, and a done pulse.
- Placement is pseudo-random: a free-running LFSR drives it, with a bounded retry count and a deterministic fallback layout.

Parameters:
- BOARD_N, 5, board dimension (rows = cols).
- MAX_SHIPS, 5, upper clamp on the requested ship count.
- MAX_TRIES, 32, failed random attempts allowed per ship before fallback. 0 forces immediate fallback.
- SEED, 16'hACE1, LFSR value loaded on reset. Must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to build a new fleet
- ship_count  in  3  requested number of ships
- tablero_pc  out  5x5x2  PC board, cell codes from the package
- pc_ships  out  3  ships committed so far
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the fleet is complete
- placement_fallback  out  1  sticky: last fleet used the fixed layout

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - all cells CELL_WATER; pc_ships=0; busy=0; done=0; placement_fallback=0.
  - LFSR=SEED; FSM=IDLE.
  - rst mid-operation aborts at once, with the same values.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle regardless of state, including in IDLE, so the player's timing adds entropy.
- Clamping: N = min(ship_count, MAX_SHIPS), latched on start.
- Ship lengths: ships are placed largest first; ship k has length L=k for k=N down to 1. N=5 gives 15 ship cells.
- States:
  - IDLE: start=1 -> CLEAR. start ignored in every other state.
  - CLEAR: all cells WATER, pc_ships=0, placement_fallback=0, tries=0, L=N. If N=0 -> DONE, else -> PICK.
  - PICK: sample LFSR: row=lfsr[2:0], col=lfsr[5:3], vert=lfsr[6].
    - Reject if row>=5, col>=5, (vert and row+L>5), or (!vert and col+L>5).
    - Reject: tries+1. If tries reaches MAX_TRIES -> FALLBACK, else stay in PICK.
    - Accept -> CHECK with idx=0.
  - CHECK: one cell per cycle along the ship.
    - Cell not WATER -> reject: tries+1, then PICK or FALLBACK as above.
    - idx=L-1 and clean -> COMMIT with idx=0.
  - COMMIT: write CELL_SHIP to one cell per cycle. At idx=L-1:
    - pc_ships+1, tries=0, L-1.
    - L becomes 0 -> DONE, else -> PICK.
  - FALLBACK: one cycle.
    - Clears the board, then writes the fixed layout: ship of length L on row L-1, cols 0..L-1, for L=1..N.
    - pc_ships=N, placement_fallback=1 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Board hold: the board holds in IDLE until the next accepted start or rst.
- Latency bound: worst case per ship is MAX_TRIES*(1+L)+L+1 cycles, so the whole operation is bounded.
- Board writes happen only in CLEAR, COMMIT and FALLBACK. Cells never hold HIT or MISS codes from this block.
- Output registration:
  - All outputs are registered.
  - busy rises the cycle after start.
  - tablero_pc is stable while busy=0.

Decomposition:
- Shared package battleship_pkg:
  - cell codes CELL_WATER=2'b00, CELL_SHIP=2'b01, CELL_HIT=2'b10, CELL_MISS=2'b11.
  - BOARD_N, MAX_SHIPS, board typedef (2-bit 5x5 array).
  - placer state enum.
- One sub-module: lfsr16 (clk, rst, seed, q[15:0]), reused later by the PC-turn attack logic.

Test Plan:
- Reset check: assert rst 2 cycles -> all 25 cells 2'b00, pc_ships=0, busy=0, done=0, placement_fallback=0.
- Three ships: ship_count=3, start pulse -> one done pulse within bound. Then:
  - exactly 6 CELL_SHIP cells forming straight runs of 3, 2 and 1.
  - runs do not overlap and none goes off-board.
  - pc_ships=3.
- Clamp: ship_count=7 -> N=5; 15 ship cells in runs of 5, 4, 3, 2, 1; pc_ships=5.
- Zero ships: ship_count=0 -> done exactly 3 cycles after start (busy, CLEAR, DONE); board all water; pc_ships=0.
- Forced fallback: MAX_TRIES=0, ship_count=4 -> ship cells only at:
  - (0,0)
  - (1,0..1)
  - (2,0..2)
  - (3,0..3)
  - placement_fallback=1, pc_ships=4.
- Abort and ignore cases:
  - rst during COMMIT of the second ship -> next cycle board all water, pc_ships=0, busy=0.
  - A following start completes normally.
  - start asserted while busy is ignored: one done pulse only.
